// File: rtl/dram_access_ctrl_pkg.sv
// Shared parameters, FSM encoding and request validation for the dram access controller.
package dram_access_ctrl_pkg;

  localparam int ADDRESS_BUS_WIDTH = 8;
  localparam int DATA_BUS_WIDTH    = 24;
  localparam int NUM_ADDRESS       = 256;
  localparam int MAX_BURST         = 8;
  localparam int LEN_WIDTH         = 4;

  // One extra address bit so start+length can be compared without wrapping.
  localparam int ADDR_EXT_WIDTH = ADDRESS_BUS_WIDTH + 1;
  localparam logic [ADDR_EXT_WIDTH-1:0] ADDR_LIMIT    = ADDR_EXT_WIDTH'(NUM_ADDRESS);
  localparam logic [LEN_WIDTH-1:0]      MAX_BURST_LEN = LEN_WIDTH'(MAX_BURST);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RD_ISSUE = 3'd1,
    RD_DRAIN = 3'd2,
    RD_LAST  = 3'd3,
    WR_ISSUE = 3'd4,
    RESP     = 3'd5
  } state_t;

  // A request is rejected when it would touch a word outside the dram or asks
  // for an empty or oversized burst; rejected requests never reach the dram.
  function automatic logic request_error(input logic                         is_write,
                                         input logic [ADDRESS_BUS_WIDTH-1:0] addr,
                                         input logic [LEN_WIDTH-1:0]         len);
    logic [ADDR_EXT_WIDTH-1:0] addr_ext;
    logic [ADDR_EXT_WIDTH-1:0] end_ext;
    addr_ext = {1'b0, addr};
    end_ext  = addr_ext + {{(ADDR_EXT_WIDTH-LEN_WIDTH){1'b0}}, len};
    if (is_write) return (addr_ext >= ADDR_LIMIT);
    return (len == '0) || (len > MAX_BURST_LEN) || (end_ext > ADDR_LIMIT);
  endfunction

endpackage

// File: rtl/dram_access_ctrl_if.sv
// Request/response handshake plus dram pin bundle. The controller is the
// initiator on this bus (master); the requester and the dram form the slave side.
interface dram_access_ctrl_if;
  import dram_access_ctrl_pkg::*;

  logic                         req_valid;
  logic                         req_ready;
  logic                         req_write;
  logic [ADDRESS_BUS_WIDTH-1:0] req_addr;
  logic [DATA_BUS_WIDTH-1:0]    req_wdata;
  logic [LEN_WIDTH-1:0]         req_len;
  logic                         rsp_valid;
  logic [DATA_BUS_WIDTH-1:0]    rsp_data;
  logic                         rsp_last;
  logic                         rsp_err;
  logic [ADDRESS_BUS_WIDTH-1:0] mem_address;
  logic [DATA_BUS_WIDTH-1:0]    mem_write_data;
  logic                         mem_read_not_write;
  logic                         mem_cs;
  logic [DATA_BUS_WIDTH-1:0]    mem_read_data;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata, req_len, mem_read_data,
    output req_ready, rsp_valid, rsp_data, rsp_last, rsp_err,
           mem_address, mem_write_data, mem_read_not_write, mem_cs
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata, req_len, mem_read_data,
    input  req_ready, rsp_valid, rsp_data, rsp_last, rsp_err,
           mem_address, mem_write_data, mem_read_not_write, mem_cs
  );

endinterface

// File: rtl/dram_access_ctrl_mem_burst_counter.sv
// Burst bookkeeping: walks the dram address and tracks how many issues and
// captures remain so the FSM knows the final word of each phase.
module mem_burst_counter
  import dram_access_ctrl_pkg::*;
(
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         load,
  input  logic [ADDRESS_BUS_WIDTH-1:0] start_addr,
  input  logic [LEN_WIDTH-1:0]         len,
  input  logic                         issue_step,
  input  logic                         capture_step,
  output logic [ADDRESS_BUS_WIDTH-1:0] addr,
  output logic                         last_issue,
  output logic                         last_capture
);

  logic [LEN_WIDTH-1:0] issue_left;
  logic [LEN_WIDTH-1:0] capture_left;

  assign last_issue   = (issue_left == LEN_WIDTH'(1));
  assign last_capture = (capture_left == LEN_WIDTH'(1));

  // Address holds on the final issue so it never steps past the end of the dram.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      addr         <= '0;
      issue_left   <= '0;
      capture_left <= '0;
    end else if (load) begin
      addr         <= start_addr;
      issue_left   <= len;
      capture_left <= len;
    end else begin
      if (issue_step && !last_issue) addr <= addr + ADDRESS_BUS_WIDTH'(1);
      if (issue_step && (issue_left != '0)) issue_left <= issue_left - LEN_WIDTH'(1);
      if (capture_step && (capture_left != '0)) capture_left <= capture_left - LEN_WIDTH'(1);
    end
  end

endmodule

// File: rtl/dram_access_ctrl.sv
// Data-memory initiator: turns single writes and short read bursts into dram
// cycles and returns each word with valid/last/err. Every output is registered.
module dram_access_ctrl
  import dram_access_ctrl_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  dram_access_ctrl_if.master bus
);

  state_t state;
  state_t next_state;

  logic                         accept;
  logic                         req_err;
  logic                         ready_q;
  logic                         mem_cs_q, mem_cs_n;
  logic                         mem_rnw_q, mem_rnw_n;
  logic [DATA_BUS_WIDTH-1:0]    mem_wdata_q, mem_wdata_n;
  logic                         data_valid_q;
  logic                         rsp_valid_q, rsp_valid_n;
  logic                         rsp_last_q, rsp_last_n;
  logic                         rsp_err_q, rsp_err_n;
  logic [DATA_BUS_WIDTH-1:0]    rsp_data_q, rsp_data_n;
  logic [ADDRESS_BUS_WIDTH-1:0] burst_addr;
  logic                         last_issue;
  logic                         last_capture;

  // Ready is masked by reset so nothing can be accepted while rst_n is low.
  assign bus.req_ready = ready_q & rst_n;
  assign accept        = bus.req_valid & bus.req_ready;
  assign req_err       = request_error(bus.req_write, bus.req_addr, bus.req_len);

  mem_burst_counter u_counter (
    .clk          (clk),
    .rst_n        (rst_n),
    .load         (accept && !req_err),
    .start_addr   (bus.req_addr),
    .len          (bus.req_len),
    .issue_step   (state == RD_ISSUE),
    .capture_step (data_valid_q),
    .addr         (burst_addr),
    .last_issue   (last_issue),
    .last_capture (last_capture)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // Next-state logic: reads drain two cycles after the final issue, writes and rejects end in RESP.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:     if (accept) next_state = req_err ? RESP : (bus.req_write ? WR_ISSUE : RD_ISSUE);
      RD_ISSUE: if (last_issue) next_state = RD_DRAIN;
      RD_DRAIN: next_state = RD_LAST;
      RD_LAST:  next_state = IDLE;
      WR_ISSUE: next_state = RESP;
      RESP:     next_state = IDLE;
      default:  next_state = IDLE;
    endcase
  end

  // Output logic: computes the value every output register takes at the coming edge.
  always_comb begin
    mem_cs_n    = (next_state == RD_ISSUE) || (next_state == WR_ISSUE);
    mem_rnw_n   = (next_state != WR_ISSUE);
    mem_wdata_n = (accept && bus.req_write) ? bus.req_wdata : mem_wdata_q;
    rsp_valid_n = data_valid_q || (next_state == RESP);
    rsp_last_n  = (data_valid_q && last_capture) || (next_state == RESP);
    rsp_err_n   = accept && req_err;
    rsp_data_n  = data_valid_q ? bus.mem_read_data : '0;
  end

  // Output registers; data_valid_q marks the cycle after a dram read, the only time read data is sampled.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ready_q      <= 1'b1;
      mem_cs_q     <= 1'b0;
      mem_rnw_q    <= 1'b1;
      mem_wdata_q  <= '0;
      data_valid_q <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_last_q   <= 1'b0;
      rsp_err_q    <= 1'b0;
      rsp_data_q   <= '0;
    end else begin
      ready_q      <= (next_state == IDLE);
      mem_cs_q     <= mem_cs_n;
      mem_rnw_q    <= mem_rnw_n;
      mem_wdata_q  <= mem_wdata_n;
      data_valid_q <= mem_cs_q && mem_rnw_q;
      rsp_valid_q  <= rsp_valid_n;
      rsp_last_q   <= rsp_last_n;
      rsp_err_q    <= rsp_err_n;
      rsp_data_q   <= rsp_data_n;
    end
  end

  assign bus.mem_cs             = mem_cs_q;
  assign bus.mem_read_not_write = mem_rnw_q;
  assign bus.mem_address        = burst_addr;
  assign bus.mem_write_data     = mem_wdata_q;
  assign bus.rsp_valid          = rsp_valid_q;
  assign bus.rsp_last           = rsp_last_q;
  assign bus.rsp_err            = rsp_err_q;
  assign bus.rsp_data           = rsp_data_q;

endmodule

// File: doc/dram_access_ctrl.md
Name: dram_access_ctrl

Overview:
- Initiator side of the data-memory bus: the CPU load/store path issues single reads, single writes or short read bursts here.
- Drives the dram port (address, write_data, read_not_write, cs) with the required timing and captures read_data.
- Returns each word to the requester with valid/last/err flags.
- Sits between the CPU execute/memory stage and the dram instance.

Parameters:
- ADDRESS_BUS_WIDTH, 8, word-address width (from params.v)
- DATA_BUS_WIDTH, 24, data word width (from params.v)
- NUM_ADDRESS, 256, number of words in dram (from params.v)
- MAX_BURST, 8, maximum read-burst length in words
- LEN_WIDTH, 4, width of req_len; must hold MAX_BURST

Ports:
- clk  in  1  system clock, all logic on posedge
- rst_n  in  1  synchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  controller idle; request accepted on the edge where req_valid & req_ready
- req_write  in  1  1=single write, 0=read burst
- req_addr  in  ADDRESS_BUS_WIDTH  start word address
- req_wdata  in  DATA_BUS_WIDTH  write data
- req_len  in  LEN_WIDTH  read burst length in words (ignored for writes)
- rsp_valid  out  1  response word/ack valid, one-cycle pulse per word
- rsp_data  out  DATA_BUS_WIDTH  read word (0 for write ack or error)
- rsp_last  out  1  final response of the request
- rsp_err  out  1  request rejected; no memory access performed
- mem_address  out  ADDRESS_BUS_WIDTH  to dram address
- mem_write_data  out  DATA_BUS_WIDTH  to dram write_data
- mem_read_not_write  out  1  to dram read_not_write
- mem_cs  out  1  to dram cs
- mem_read_data  in  DATA_BUS_WIDTH  from dram read_data; valid only in the cycle after a cs=1 read cycle, Z otherwise

Behaviour:
- Reset: rst_n low at a posedge puts the FSM in IDLE. Values after that edge:
  - mem_cs=0, mem_read_not_write=1, mem_address=0, mem_write_data=0
  - rsp_valid=0, rsp_last=0, rsp_err=0, rsp_data=0
  - req_ready=1 (forced to 0 while rst_n is low; requests are ignored during reset)
- All outputs are registered. The dram samples cs/address at the posedge ending a cycle and presents read data throughout the following cycle.
- FSM states: IDLE, RD_ISSUE, RD_DRAIN, RD_LAST, WR_ISSUE, RESP.
- req_ready=1 only in IDLE. No response backpressure: the consumer must take every rsp_valid.
- Cycle numbering: acceptance edge E0, then cycles C1, C2, ...
- Read of L words at address A (1 <= L <= MAX_BURST, A+L <= NUM_ADDRESS):
  - Cycles C1..CL: RD_ISSUE, mem_cs=1, mem_read_not_write=1, mem_address=A+i-1 in Ci.
  - C(L+1): RD_DRAIN, mem_cs=0.
  - Word i appears on mem_read_data in C(i+1), is registered at the end of that cycle, and is presented with rsp_valid=1 in C(i+2).
  - rsp_last=1 only with word L, in C(L+2).
  - C(L+3): IDLE, req_ready=1.
- Write at A (A < NUM_ADDRESS):
  - C1: WR_ISSUE, mem_cs=1, mem_read_not_write=0, mem_address=A, mem_write_data=req_wdata.
  - C2: RESP, rsp_valid=1, rsp_last=1, rsp_data=0.
  - C3: IDLE.
- Error cases: read with L=0, L>MAX_BURST or A+L>NUM_ADDRESS; write with A>=NUM_ADDRESS.
  - mem_cs stays 0 throughout.
  - C1: RESP, rsp_valid=1, rsp_err=1, rsp_last=1.
  - C2: IDLE.
- Bound check uses ADDRESS_BUS_WIDTH+1-bit arithmetic; no address wrap is ever issued.
- req_* fields are latched at acceptance; later input changes have no effect on the request in flight.
- Outside issue cycles: mem_cs=0 and mem_read_not_write=1. mem_read_data is never sampled when not valid.
- Reset mid-operation: the burst is abandoned at the reset edge and no further rsp_valid is produced. A partial burst already issued leaves memory unchanged; reads have no side effects.

Decomposition:
- params.v holds ADDRESS_BUS_WIDTH, DATA_BUS_WIDTH, NUM_ADDRESS, MAX_BURST, LEN_WIDTH and the FSM state encodings.
- One sub-module, mem_burst_counter: loads the start address and length, increments the address, and flags the final issue and final capture.
- FSM and response registers stay in dram_access_ctrl.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with req_valid=1 -> mem_cs=0, rsp_valid=0 throughout; req_ready=1 in the cycle after rst_n returns to 1.
- Single read, dram preloaded mem[16]=10: read A=16, L=1 -> rsp_valid, rsp_data=10, rsp_last=1 exactly in C3; req_ready=1 in C4.
- Write then read: write A=40, data 24'h00ABCD -> ack in C2. Then read A=40, L=1 -> rsp_data=24'h00ABCD.
- Burst: preload mem[30..33]=1,2,3,4; read A=30, L=4 -> mem_address 30,31,32,33 in C1..C4; rsp_data 1,2,3,4 in C3..C6; rsp_last only in C6.
- Errors:
  - read A=254, L=4 -> C1 rsp_err=1, rsp_last=1, mem_cs never 1.
  - read L=0 -> same response.
  - write A=255 -> accepted normally (255 < NUM_ADDRESS).
- Reset mid-burst: read A=30, L=8, rst_n=0 during C4 -> from the next edge mem_cs=0, rsp_valid=0. After release, read A=32, L=1 returns 3.
